// File: rtl/dffram_arb_pkg.sv
// dffram_arb_pkg: shared types and RAM geometry for the DFFRAM arbiter
package dffram_arb_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW = 8;
  typedef logic port_id_t;
endpackage

// File: rtl/dffram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a bounded grant lock
module rr_arb2
  import dffram_arb_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant
);
  port_id_t last_grant, lock_owner, win;
  logic lock_act, any;
  logic [7:0] lock_cnt, base_cnt;
  always_comb begin
    any = en && |valid;
    win = valid[1] && (!valid[0] || (lock_act ? lock_owner : !last_grant));
    grant = any ? (win ? 2'b10 : 2'b01) : 2'b00;
    base_cnt = (lock_act && lock_owner == win) ? lock_cnt : 8'd0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      last_grant <= 1'b1;
      lock_owner <= 1'b0;
      lock_act <= 1'b0;
      lock_cnt <= 8'd0;
    end else if (any) begin
      last_grant <= win;
      if (lock[win] && ({1'b0, base_cnt} + 9'd1 < 9'(MAX_LOCK))) begin
        lock_act <= 1'b1;
        lock_owner <= win;
        lock_cnt <= base_cnt + 8'd1;
      end else begin
        lock_act <= 1'b0;
        lock_owner <= 1'b0;
        lock_cnt <= 8'd0;
      end
    end else if (lock_act && !valid[lock_owner]) begin
      lock_act <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt <= 8'd0;
    end
endmodule

// File: rtl/dffram_arbiter.sv
// dffram_arbiter: shares one RAM256 between two requesters with an init sweep
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int WSIZE = 2,
  parameter bit INIT_EN = 1'b1,
  parameter logic [8*WSIZE-1:0] INIT_VALUE = '0,
  parameter int MAX_LOCK = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 busy,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic                 r0_lock,
  input  logic [WSIZE-1:0]     r0_we,
  input  logic [RAM_AW-1:0]    r0_addr,
  input  logic [8*WSIZE-1:0]   r0_wdata,
  output logic                 r0_rvalid,
  output logic [8*WSIZE-1:0]   r0_rdata,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic                 r1_lock,
  input  logic [WSIZE-1:0]     r1_we,
  input  logic [RAM_AW-1:0]    r1_addr,
  input  logic [8*WSIZE-1:0]   r1_wdata,
  output logic                 r1_rvalid,
  output logic [8*WSIZE-1:0]   r1_rdata,
  output logic                 ram_en,
  output logic [WSIZE-1:0]     ram_we,
  output logic [RAM_AW-1:0]    ram_a,
  output logic [8*WSIZE-1:0]   ram_di,
  input  logic [8*WSIZE-1:0]   ram_do
);
  state_e state, state_nx;
  logic [RAM_AW-1:0] init_addr;
  logic [1:0] grant;
  logic run, sweep;
  assign run = !rst && state == RUN;
  assign sweep = !rst && state == INIT;
  assign busy = rst ? INIT_EN : state == INIT;
  assign r0_ready = grant[0];
  assign r1_ready = grant[1];
  assign r0_rdata = ram_do;
  assign r1_rdata = ram_do;
  rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk(clk), .rst(rst), .en(run),
    .valid({r1_valid, r0_valid}), .lock({r1_lock, r0_lock}), .grant(grant)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT_EN ? INIT : RUN;
      init_addr <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      state <= state_nx;
      init_addr <= state == INIT ? init_addr + 8'd1 : init_addr;
      r0_rvalid <= grant[0] && r0_we == '0;
      r1_rvalid <= grant[1] && r1_we == '0;
    end
  always_comb begin
    state_nx = (sweep && init_addr == RAM_AW'(RAM_DEPTH - 1)) ? RUN : state;
    ram_en = sweep || (run && |grant);
    ram_we = sweep ? '1 : grant[1] ? r1_we : grant[0] ? r0_we : '0;
    ram_a = sweep ? init_addr : grant[1] ? r1_addr : grant[0] ? r0_addr : '0;
    ram_di = sweep ? INIT_VALUE : grant[1] ? r1_wdata : grant[0] ? r0_wdata : '0;
  end
endmodule

// File: tb/tb_dffram_arbiter.sv
// tb_dffram_arbiter: directed table and sequence checks of the DFFRAM arbiter
module tb_dffram_arbiter;
  logic clk = 1'b0, rst = 1'b1, busy;
  logic r0_valid = 1'b0, r0_ready, r0_lock = 1'b0, r0_rvalid;
  logic [1:0] r0_we = 2'b00;
  logic [7:0] r0_addr = 8'h00;
  logic [15:0] r0_wdata = 16'h0, r0_rdata;
  logic r1_valid = 1'b0, r1_ready, r1_lock = 1'b0, r1_rvalid;
  logic [1:0] r1_we = 2'b00;
  logic [7:0] r1_addr = 8'h00;
  logic [15:0] r1_wdata = 16'h0, r1_rdata;
  logic ram_en;
  logic [1:0] ram_we;
  logic [7:0] ram_a;
  logic [15:0] ram_di, ram_do;
  logic [15:0] mem [256];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  dffram_arbiter #(.WSIZE(2), .INIT_EN(1'b1), .INIT_VALUE(16'hA5A5), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_lock(r0_lock), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_lock(r1_lock), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we[0]) mem[ram_a][7:0] <= ram_di[7:0];
      if (ram_we[1]) mem[ram_a][15:8] <= ram_di[15:8];
      ram_do <= mem[ram_a];
    end
  typedef struct {
    logic v0; logic [1:0] we0; logic [7:0] a0; logic [15:0] d0;
    logic v1; logic [1:0] we1; logic [7:0] a1; logic [15:0] d1;
    logic rdy0; logic rdy1; logic en; logic [7:0] a;
    logic rv0; logic rv1; logic [15:0] rd;
  } vec_t;
  vec_t tv [11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle();
    r0_valid = 1'b0; r0_lock = 1'b0; r0_we = 2'b00;
    r1_valid = 1'b0; r1_lock = 1'b0; r1_we = 2'b00;
  endtask
  task automatic sweep_check();
    int n;
    n = 0;
    r0_valid = 1'b1; r0_we = 2'b00; r1_valid = 1'b1; r1_we = 2'b00;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("ready_in_sweep", {r0_ready, r1_ready}, 0);
    end
    chk("busy_cycles", n, 256);
    idle();
  endtask
  task automatic r0_access(input logic [1:0] we, input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    #1 idle();
    r0_valid = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{1'b1, 2'b00, 8'h37, 16'h0000, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 2'b11, 8'h10, 16'h1234, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 16'hA5A5};
    tv[2]  = '{1'b1, 2'b10, 8'h10, 16'hFF00, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 16'h0000};
    tv[3]  = '{1'b1, 2'b00, 8'h10, 16'h0000, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 16'h0000};
    tv[4]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 2'b11, 8'h01, 16'h1111, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 16'hFF34};
    tv[5]  = '{1'b1, 2'b11, 8'h02, 16'h2222, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 16'h0000};
    tv[6]  = '{1'b1, 2'b00, 8'h01, 16'h0000, 1'b1, 2'b00, 8'h02, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 16'h0000};
    tv[7]  = '{1'b1, 2'b00, 8'h01, 16'h0000, 1'b1, 2'b00, 8'h02, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 16'h2222};
    tv[8]  = '{1'b1, 2'b00, 8'h01, 16'h0000, 1'b1, 2'b00, 8'h02, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 16'h1111};
    tv[9]  = '{1'b1, 2'b00, 8'h01, 16'h0000, 1'b1, 2'b00, 8'h02, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 16'h2222};
    tv[10] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1111};
    r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sweep_check();
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      r0_valid = tv[i].v0; r0_we = tv[i].we0; r0_addr = tv[i].a0; r0_wdata = tv[i].d0;
      r1_valid = tv[i].v1; r1_we = tv[i].we1; r1_addr = tv[i].a1; r1_wdata = tv[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d_r0_ready", i), r0_ready, tv[i].rdy0);
      chk($sformatf("v%0d_r1_ready", i), r1_ready, tv[i].rdy1);
      chk($sformatf("v%0d_ram_en", i), ram_en, tv[i].en);
      if (tv[i].en) chk($sformatf("v%0d_ram_a", i), ram_a, tv[i].a);
      chk($sformatf("v%0d_r0_rvalid", i), r0_rvalid, tv[i].rv0);
      chk($sformatf("v%0d_r1_rvalid", i), r1_rvalid, tv[i].rv1);
      if (tv[i].rv0) chk($sformatf("v%0d_r0_rdata", i), r0_rdata, tv[i].rd);
      if (tv[i].rv1) chk($sformatf("v%0d_r1_rdata", i), r1_rdata, tv[i].rd);
    end
    for (int c = 0; c < 21; c++) begin
      @(posedge clk);
      #1;
      r0_valid = 1'b1; r0_we = 2'b00; r0_addr = 8'h01;
      r1_valid = 1'b1; r1_lock = 1'b1; r1_we = 2'b11; r1_addr = 8'h80 + 8'(c); r1_wdata = 16'hBE00 + 16'(c);
      @(negedge clk);
      chk($sformatf("lock_c%0d_r1_ready", c), r1_ready, c != 16);
      chk($sformatf("lock_c%0d_r0_ready", c), r0_ready, c == 16);
      if (c == 1) chk("lock_write_no_rvalid", r1_rvalid, 0);
      if (c == 17) begin
        chk("lock_r0_rvalid", r0_rvalid, 1);
        chk("lock_r0_rdata", r0_rdata, 16'h1111);
      end
    end
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1;
    r0_valid = 1'b1; r0_addr = 8'h01; r1_valid = 1'b1; r1_addr = 8'h02;
    @(negedge clk);
    chk("lock_cleared_r0_wins", {r1_ready, r0_ready}, 2'b01);
    for (int i = 0; i < 256; i++) r0_access(2'b11, 8'(i), 16'(i));
    for (int i = 0; i <= 256; i++) begin
      @(posedge clk);
      #1 idle();
      if (i < 256) begin
        r0_valid = 1'b1; r0_addr = 8'(i);
      end
      @(negedge clk);
      chk($sformatf("bb_%0d_rvalid", i), r0_rvalid, i > 0);
      if (i > 0) chk($sformatf("bb_%0d_rdata", i), r0_rdata, 16'(i - 1));
    end
    r0_access(2'b00, 8'h05, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_ready", r0_ready, 0);
    @(negedge clk);
    chk("midrst_rvalid", r0_rvalid, 0);
    chk("midrst_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("sweep100_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sweep_check();
    r0_access(2'b00, 8'h05, 16'h0);
    r0_access(2'b00, 8'hFF, 16'h0);
    @(negedge clk);
    chk("post_sweep_05_rdata", r0_rdata, 16'hA5A5);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("post_sweep_ff_rvalid", r0_rvalid, 1);
    chk("post_sweep_ff_rdata", r0_rdata, 16'hA5A5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dffram_arbiter.md
Name: dffram_arbiter

Overview:
Shares one 256-entry DFFRAM macro (RAM256, WSIZE bytes per word) between two requesters: port 0 (host/lookup side) and port 1 (SPI line-fill side). After reset it runs an init sweep that writes INIT_VALUE to every word, for example to clear tags and valid bits. Arbitration is round-robin. A requester can lock the grant for a bounded burst. Read data is returned with fixed 1-cycle latency, matching the macro's registered Do0.

Parameters:
WSIZE, 2, bytes per RAM word; data width DW = 8*WSIZE
INIT_EN, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN
INIT_VALUE, 0, word value written during the sweep (DW bits)
MAX_LOCK, 16, maximum number of consecutive locked beats before the grant must yield (range 1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
busy  out  1  high while the init sweep is in progress
rN_valid  in  1  request valid (N = 0,1; one set of these ports per requester)
rN_ready  out  1  request accepted this cycle
rN_lock  in  1  keep the grant after this beat
rN_we  in  WSIZE  byte write enables; 0 = read
rN_addr  in  8  word address
rN_wdata  in  DW  write data
rN_rvalid  out  1  read data valid on rN_rdata
rN_rdata  out  DW  read data
ram_en  out  1  to EN0
ram_we  out  WSIZE  to WE0
ram_a  out  8  to A0
ram_di  out  DW  to Di0
ram_do  in  DW  from Do0

Behaviour:
- Reset: synchronous, active-high, applied at any time including mid-sweep or mid-burst.
  - Registered outputs after reset: rN_rvalid=0.
  - Combinational outputs during reset: ram_en=0, ram_we=0, rN_ready=0. No access reaches the RAM.
  - State after reset: init_addr=0, last_grant=1 (so port 0 wins the first tie), lock_cnt=0, lock_owner cleared.
  - busy=1 if INIT_EN, else 0.
- FSM states: INIT, RUN.
- INIT (one word per cycle, 256 cycles):
  - ram_en=1, ram_we=all ones, ram_a=init_addr, ram_di=INIT_VALUE.
  - init_addr increments each cycle.
  - On the cycle init_addr==255 the FSM moves to RUN, so busy drops on the next cycle.
  - rN_ready=0 throughout INIT.
- RUN, grant selection (combinational, same cycle):
  - Only one valid: that requester wins.
  - Both valid with an active lock owner: the owner wins.
  - Both valid, no lock owner: the port that is not last_grant wins.
- Winner outputs: rW_ready=1, ram_en=1, ram_we/ram_a/ram_di=winner's rW_we/rW_addr/rW_wdata. The loser's ready=0.
- Neither valid: ram_en=0, ram_we=0.
- A beat is accepted when valid && ready. On acceptance, last_grant <= winner.
- Lock counting, per accepted beat:
  - If rW_lock=1 and lock_cnt+1 < MAX_LOCK: lock_owner <= W, lock_cnt++.
  - Otherwise lock_owner is cleared and lock_cnt <= 0.
  - Lock also clears when the owner deasserts valid for a cycle.
  - MAX_LOCK caps a locked burst at exactly MAX_LOCK beats; the other port wins the next cycle if valid.
- Read response:
  - An accepted beat with rW_we==0 sets rW_rvalid=1 in the following cycle only.
  - rN_rdata = ram_do (pass-through) and is meaningful only while rN_rvalid=1.
  - Reads are fully pipelined: back-to-back reads return back-to-back rvalid.
- Writes give no response. Partial byte enables update only the selected bytes (RAM semantics).
- A write followed by a read of the same address in the next cycle returns the new data.
- Simultaneous port 0 write and port 1 read to the same address: only one is granted, so there is no hazard.

Decomposition:
- Package dffram_arb_pkg:
  - state_e {INIT, RUN}
  - constant RAM_DEPTH=256, RAM_AW=8
  - typedef port_id_t (1 bit)
- One sub-module, rr_arb2: a 2-way round-robin arbiter with lock and MAX_LOCK counter (inputs: valid[1:0], lock[1:0]; outputs: grant one-hot; holds last_grant, lock_owner, lock_cnt).
- The top level holds the INIT FSM, RAM muxing and rvalid pipeline. Benches use RAM256model under Verilator and the RAM256 GL model under Icarus.

Test Plan:
1. Reset, INIT_EN=1, INIT_VALUE=16'hA5A5 -> busy high for exactly 256 cycles. r0 read at 8'h37 then returns 16'hA5A5 with r0_rvalid one cycle after r0_ready.
2. r0 writes 16'h1234 to 8'h10 with we=2'b11, then writes 16'hFF00 with we=2'b10; r0 reads 8'h10 -> 16'hFF34.
3. Both ports hold valid reads continuously to 8'h01 and 8'h02 -> grants alternate 0,1,0,1. Each rvalid lands on the correct port with correct data.
4. r1 holds valid+lock for 20 write beats while r0 is also valid, MAX_LOCK=16 -> r1 gets exactly 16 consecutive grants, then r0 is granted once, then r1 resumes.
5. Assert rst at sweep cycle 100 -> busy stays high and the sweep restarts at address 0 (256 full cycles). No rN_ready during the sweep.
6. Back-to-back r0 reads of addresses 0..255 after a write of addr=data -> r0_rvalid high every cycle and r0_rdata==address, 1-cycle latency.
